// File: rtl/vga_pkg.sv
// Shared types, colours and edge-mode constants for the sprite field display path.
package vga_pkg;

  localparam int RGB_W = 12;

  typedef logic [RGB_W-1:0] rgb_t;
  typedef logic [9:0]       pos_t;

  localparam rgb_t RED        = 12'hF00;
  localparam rgb_t GREEN      = 12'h0F0;
  localparam rgb_t BLUE       = 12'h00F;
  localparam rgb_t WHITE      = 12'hCCC;
  localparam rgb_t WHITE_HI   = 12'hFFF;
  localparam rgb_t BACKGROUND = 12'h113;
  localparam rgb_t BLACK      = 12'h000;

  localparam rgb_t SPRITE_PALETTE [0:7] = '{
    RED, GREEN, BLUE, 12'hFF0, 12'h0FF, 12'hF0F, 12'hF80, WHITE
  };

  localparam bit WRAP_MODE  = 1'b1;
  localparam bit CLAMP_MODE = 1'b0;

endpackage

// File: rtl/sprite_pos.sv
// One sprite's position registers with step, wrap-around or clamp at the visible edges.
module sprite_pos
  import vga_pkg::*;
#(
  parameter pos_t INIT_X = 10'd303,
  parameter pos_t INIT_Y = 10'd274,
  parameter int   H_MIN  = 144,
  parameter int   H_MAX  = 783,
  parameter int   V_MIN  = 35,
  parameter int   V_MAX  = 514,
  parameter int   STEP   = 2,
  parameter bit   WRAP   = WRAP_MODE
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic right,
  input  logic left,
  input  logic up,
  input  logic down,
  output pos_t x,
  output pos_t y
);

  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic signed [10:0] XMIN_S = 11'(H_MIN);
  localparam logic signed [10:0] XMAX_S = 11'(H_MAX);
  localparam logic signed [10:0] YMIN_S = 11'(V_MIN);
  localparam logic signed [10:0] YMAX_S = 11'(V_MAX);

  logic signed [10:0] nx, ny;
  pos_t x_next, y_next;

  always_comb begin
    nx = signed'({1'b0, x});
    ny = signed'({1'b0, y});
    if (right)     nx = nx + STEP_S;
    else if (left) nx = nx - STEP_S;
    else if (up)   ny = ny - STEP_S;
    else if (down) ny = ny + STEP_S;

    if (nx > XMAX_S)      x_next = WRAP ? pos_t'(H_MIN) : pos_t'(H_MAX);
    else if (nx < XMIN_S) x_next = WRAP ? pos_t'(H_MAX) : pos_t'(H_MIN);
    else                  x_next = nx[9:0];

    if (ny > YMAX_S)      y_next = WRAP ? pos_t'(V_MIN) : pos_t'(V_MAX);
    else if (ny < YMIN_S) y_next = WRAP ? pos_t'(V_MAX) : pos_t'(V_MIN);
    else                  y_next = ny[9:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= INIT_X;
      y <= INIT_Y;
    end else if (en) begin
      x <= x_next;
      y <= y_next;
    end
  end

endmodule

// File: rtl/sprite_field_controller.sv
// Sprite field: selection, per-pixel hit/priority colour with one-cycle registered output,
// and a per-frame overlap flag.
module sprite_field_controller
  import vga_pkg::*;
#(
  parameter int NUM_SPRITES = 3,
  parameter int H_MIN       = 144,
  parameter int H_MAX       = 783,
  parameter int V_MIN       = 35,
  parameter int V_MAX       = 514,
  parameter int HALF_W      = 5,
  parameter int HALF_H      = 10,
  parameter int STEP        = 2,
  parameter bit WRAP        = WRAP_MODE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        move_tick,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        sel_next,
  input  logic        move_all,
  input  logic        bright,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  output logic [11:0] rgb,
  output logic [2:0]  sel_id,
  output logic        collision
);

  localparam logic [10:0] HW = 11'(HALF_W);
  localparam logic [10:0] HH = 11'(HALF_H);

  pos_t xs [NUM_SPRITES];
  pos_t ys [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] hit, border;
  logic [10:0] hc, vc;
  rgb_t pix;
  logic sel_border, multi_hit, sticky, frame_start;

  assign hc = {1'b0, hCount};
  assign vc = {1'b0, vCount};

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_sprite
    logic [10:0] xi, yi;

    sprite_pos #(
      .INIT_X(pos_t'(H_MIN + (i + 1) * (H_MAX - H_MIN) / (NUM_SPRITES + 1))),
      .INIT_Y(pos_t'((V_MIN + V_MAX) / 2)),
      .H_MIN (H_MIN),
      .H_MAX (H_MAX),
      .V_MIN (V_MIN),
      .V_MAX (V_MAX),
      .STEP  (STEP),
      .WRAP  (WRAP)
    ) u_pos (
      .clk  (clk),
      .rst  (rst),
      .en   (move_tick && (move_all || sel_id == 3'(i))),
      .right(right),
      .left (left),
      .up   (up),
      .down (down),
      .x    (xs[i]),
      .y    (ys[i])
    );

    assign xi = {1'b0, xs[i]};
    assign yi = {1'b0, ys[i]};
    // Sums on both sides keep the tests free of unsigned underflow near the edges.
    assign hit[i] = (xi <= hc + HW) && (hc <= xi + HW) &&
                    (yi <= vc + HH) && (vc <= yi + HH);
    assign border[i] = (hc == xi + HW) || (hc + HW == xi) ||
                       (vc == yi + HH) || (vc + HH == yi);
  end

  always_comb begin
    pix        = BACKGROUND;
    sel_border = 1'b0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit[i]) pix = SPRITE_PALETTE[i];
    end
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (hit[i] && border[i] && sel_id == 3'(i)) sel_border = 1'b1;
    end
    if (sel_border) pix = WHITE_HI;
    if (!bright)    pix = BLACK;
  end

  assign multi_hit   = ($countones(hit) > 1);
  assign frame_start = (hCount == 10'd0) && (vCount == 10'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb       <= '0;
      sel_id    <= '0;
      collision <= 1'b0;
      sticky    <= 1'b0;
    end else begin
      rgb <= pix;
      if (sel_next)
        sel_id <= (sel_id >= 3'(NUM_SPRITES - 1)) ? 3'd0 : sel_id + 3'd1;
      if (frame_start) begin
        collision <= sticky;
        sticky    <= 1'b0;
      end else if (multi_hit && bright) begin
        sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sprite_field_controller.sv
// Scoreboard bench: wrap and clamp instances share stimulus; expected colours are queued
// per probed pixel and compared one cycle later by an independent monitor.
module tb_sprite_field_controller;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic move_tick = 1'b0, up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic sel_next = 1'b0, move_all = 1'b0, bright = 1'b0;
  logic [9:0] hc = 10'd1, vc = 10'd1;
  logic [11:0] rgb_w, rgb_c;
  logic [2:0]  sel_w, sel_c;
  logic        col_w, col_c;

  always #5 clk = ~clk;

  sprite_field_controller #(.WRAP(WRAP_MODE)) u_wrap (
    .clk(clk), .rst(rst), .move_tick(move_tick), .up(up), .down(down), .left(left),
    .right(right), .sel_next(sel_next), .move_all(move_all), .bright(bright),
    .hCount(hc), .vCount(vc), .rgb(rgb_w), .sel_id(sel_w), .collision(col_w)
  );

  sprite_field_controller #(.WRAP(CLAMP_MODE)) u_clamp (
    .clk(clk), .rst(rst), .move_tick(move_tick), .up(up), .down(down), .left(left),
    .right(right), .sel_next(sel_next), .move_all(move_all), .bright(bright),
    .hCount(hc), .vCount(vc), .rgb(rgb_c), .sel_id(sel_c), .collision(col_c)
  );

  typedef struct {
    string       name;
    logic [11:0] ew;
    logic [11:0] ec;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic probe = 1'b0, probe_d = 1'b0;

  always @(posedge clk) probe_d <= probe;

  always @(negedge clk) begin
    exp_t e;
    if (probe_d) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: output presented with no expectation queued");
      end else begin
        e = q.pop_front();
        checks += 2;
        if (rgb_w !== e.ew) begin
          errors++;
          $display("FAIL %s wrap rgb: got %h want %h", e.name, rgb_w, e.ew);
        end
        if (rgb_c !== e.ec) begin
          errors++;
          $display("FAIL %s clamp rgb: got %h want %h", e.name, rgb_c, e.ec);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic mt, input logic r, input logic l, input logic u,
                       input logic d, input logic sn, input logic ma);
    @(negedge clk);
    probe = 1'b0; bright = 1'b0; hc = 10'd1; vc = 10'd1;
    move_tick = mt; right = r; left = l; up = u; down = d;
    sel_next = sn; move_all = ma;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pix(input int h, input int v, input logic b,
                     input logic [11:0] ew, input logic [11:0] ec, input string name);
    exp_t e;
    @(negedge clk);
    move_tick = 1'b0; right = 1'b0; left = 1'b0; up = 1'b0; down = 1'b0;
    sel_next = 1'b0; move_all = 1'b0;
    hc = 10'(h); vc = 10'(v); bright = b; probe = 1'b1;
    e.name = name; e.ew = ew; e.ec = ec;
    q.push_back(e);
  endtask

  task automatic frame_start();
    @(negedge clk);
    probe = 1'b0; bright = 1'b0; move_tick = 1'b0; sel_next = 1'b0;
    hc = 10'd0; vc = 10'd0;
  endtask

  task automatic chk_ctrl(input string name, input logic [2:0] es, input logic ec);
    idle();
    chk({name, "_sel_w"}, 12'(sel_w), 12'(es));
    chk({name, "_sel_c"}, 12'(sel_c), 12'(es));
    chk({name, "_col_w"}, 12'(col_w), 12'(ec));
    chk({name, "_col_c"}, 12'(col_c), 12'(ec));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_rgb_w", rgb_w, 12'h000);
    chk("reset_rgb_c", rgb_c, 12'h000);
    rst = 1'b0;
    chk_ctrl("reset", 3'd0, 1'b0);

    pix(303, 274, 1, RED, RED, "s0_center");
    pix(463, 274, 1, GREEN, GREEN, "s1_center");
    pix(623, 274, 1, BLUE, BLUE, "s2_center");
    pix(308, 274, 1, WHITE_HI, WHITE_HI, "s0_sel_border");
    pix(303, 274, 0, BLACK, BLACK, "blanked");
    pix(200, 100, 1, BACKGROUND, BACKGROUND, "background");

    // up+right together: only x moves, s0 -> (305,274)
    drive(1, 1, 0, 1, 0, 0, 0);
    pix(310, 274, 1, WHITE_HI, WHITE_HI, "right_prio_edge");
    pix(311, 274, 1, BACKGROUND, BACKGROUND, "right_prio_out");
    pix(305, 264, 1, WHITE_HI, WHITE_HI, "y_unchanged_edge");
    pix(305, 263, 1, BACKGROUND, BACKGROUND, "y_unchanged_out");

    // left with sel_next: old sprite 0 moves back to 303, selection advances
    drive(1, 0, 1, 0, 0, 1, 0);
    chk_ctrl("sel_adv", 3'd1, 1'b0);
    pix(308, 274, 1, RED, RED, "s0_unselected_edge");
    pix(309, 274, 1, BACKGROUND, BACKGROUND, "s0_moved_left");
    pix(468, 274, 1, WHITE_HI, WHITE_HI, "s1_sel_border");

    repeat (3) drive(1, 0, 0, 0, 1, 0, 1);
    pix(303, 290, 1, RED, RED, "all_down_s0");
    pix(303, 291, 1, BACKGROUND, BACKGROUND, "all_down_s0_out");
    pix(463, 270, 1, WHITE_HI, WHITE_HI, "all_down_s1");
    pix(623, 280, 1, BLUE, BLUE, "all_down_s2");

    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    chk_ctrl("sel_wrap", 3'd0, 1'b0);

    // 240 steps reach 783, the 241st wraps or clamps
    repeat (241) drive(1, 1, 0, 0, 0, 0, 0);
    pix(783, 280, 1, BACKGROUND, RED, "x_edge_783");
    pix(144, 280, 1, RED, BACKGROUND, "x_edge_144");
    pix(139, 280, 1, WHITE_HI, BACKGROUND, "x_wrap_left_border");
    pix(788, 280, 1, BACKGROUND, WHITE_HI, "x_clamp_right_border");

    // 117 steps reach 514, the 118th wraps or clamps
    repeat (118) drive(1, 0, 0, 0, 1, 0, 0);
    pix(144, 35, 1, RED, BACKGROUND, "y_edge_35");
    pix(783, 514, 1, BACKGROUND, RED, "y_edge_514");
    pix(144, 25, 1, WHITE_HI, BACKGROUND, "y_wrap_top_border");
    pix(783, 524, 1, BACKGROUND, WHITE_HI, "y_clamp_bot_border");

    drive(0, 0, 0, 0, 0, 1, 0);
    chk_ctrl("sel_s1", 3'd1, 1'b0);
    repeat (80) drive(1, 1, 0, 0, 0, 0, 0);
    pix(623, 280, 1, GREEN, GREEN, "overlap_low_index");
    pix(628, 280, 1, WHITE_HI, WHITE_HI, "overlap_sel_border");
    chk_ctrl("pre_frame", 3'd1, 1'b0);
    frame_start();
    chk_ctrl("collision_set", 3'd1, 1'b1);
    chk_ctrl("collision_hold", 3'd1, 1'b1);

    repeat (10) drive(1, 0, 1, 0, 0, 0, 0);
    pix(608, 280, 1, WHITE_HI, WHITE_HI, "separated_s1_border");
    pix(613, 280, 1, BACKGROUND, BACKGROUND, "separated_gap");
    pix(618, 280, 1, BLUE, BLUE, "separated_s2");
    frame_start();
    chk_ctrl("collision_clear", 3'd1, 1'b0);

    // asynchronous reset between clock edges drops the moved positions and selection
    pix(618, 280, 1, BLUE, BLUE, "pre_reset");
    @(negedge clk);
    probe = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rgb_w", rgb_w, 12'h000);
    chk("async_rst_rgb_c", rgb_c, 12'h000);
    chk("async_rst_sel_w", 12'(sel_w), 12'h000);
    @(negedge clk);
    rst = 1'b0;
    pix(303, 274, 1, RED, RED, "post_reset_s0");
    pix(463, 274, 1, GREEN, GREEN, "post_reset_s1");
    pix(623, 274, 1, BLUE, BLUE, "post_reset_s2");
    pix(308, 274, 1, WHITE_HI, WHITE_HI, "post_reset_sel");

    repeat (3) idle();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_field_controller.md
Name: sprite_field_controller

Overview:
- Parametrised successor to the single-block VGA mover. Holds NUM_SPRITES rectangular sprites and moves the selected one (or all of them) on a slow move_tick enable.
- Per-sprite edge handling is either wrap-around or clamp.
- Produces registered 12-bit RGB for the pixel at (hCount, vCount), plus a per-frame sprite-overlap flag.
- Sits between display_controller (hCount, vCount, bright) and the VGA output pins, in the fast pixel clock domain.

Parameters:
- NUM_SPRITES, 3, number of sprites (1..8).
- H_MIN, 144, first visible hCount.
- H_MAX, 783, last visible hCount.
- V_MIN, 35, first visible vCount.
- V_MAX, 514, last visible vCount.
- HALF_W, 5, sprite half-width in pixels.
- HALF_H, 10, sprite half-height in pixels.
- STEP, 2, pixels moved per move_tick.
- WRAP, 1, edge mode: 1 = wrap to opposite edge, 0 = clamp at edge.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset, asynchronous, active-high.
- move_tick  in  1  one-cycle movement enable (about 60 Hz, generated elsewhere).
- up  in  1  move the target sprite up (debounced level).
- down  in  1  move the target sprite down.
- left  in  1  move the target sprite left.
- right  in  1  move the target sprite right.
- sel_next  in  1  one-cycle pulse that advances the selected sprite.
- move_all  in  1  level; when 1, every sprite moves together.
- bright  in  1  display-area flag.
- hCount  in  10  current pixel column.
- vCount  in  10  current pixel row.
- rgb  out  12  registered pixel colour.
- sel_id  out  3  index of the selected sprite.
- collision  out  1  1 if two sprites overlapped anywhere in the previous frame.

Behaviour:
- Reset, asynchronous:
  - rgb = 0, sel_id = 0, collision = 0.
  - Sprite i: x = H_MIN + (i+1)*(H_MAX-H_MIN)/(NUM_SPRITES+1), y = (V_MIN+V_MAX)/2, both computed at elaboration.
  - Reset mid-frame or mid-move drops everything in progress; no partial update survives.
- Movement occurs only in a cycle where move_tick = 1:
  - Direction priority: right > left > up > down. Only one axis moves per tick.
  - Target sprites: all sprites if move_all = 1, otherwise only sprite sel_id.
  - New position is computed in 11-bit signed form: pos ± STEP.
- Edge handling, WRAP = 1:
  - x > H_MAX becomes H_MIN; x < H_MIN becomes H_MAX.
  - y > V_MAX becomes V_MIN; y < V_MIN becomes V_MAX.
- Edge handling, WRAP = 0: saturate at H_MIN/H_MAX and V_MIN/V_MAX.
- Selection:
  - sel_next advances sel_id = (sel_id+1) mod NUM_SPRITES.
  - If sel_next and move_tick coincide, the move applies to the old sel_id and the selection advances in the same edge.
- Hit test, combinational:
  - Sprite i is hit when x_i ≤ hCount+HALF_W, hCount ≤ x_i+HALF_W, y_i ≤ vCount+HALF_H and vCount ≤ y_i+HALF_H.
  - Comparisons are written this way to avoid unsigned underflow near the edges.
- Colour selection:
  - Lowest-index hit sprite wins; colour comes from the package palette indexed by sprite.
  - The selected sprite's border pixels (|dx| = HALF_W or |dy| = HALF_H) are drawn in WHITE_HI.
  - No hit gives BACKGROUND; bright = 0 forces black.
- Output latency: rgb is registered, one clk of latency from hCount/vCount/bright. The downstream sync path is delayed one cycle to match.
- Collision detection:
  - An internal sticky bit sets when two or more sprites hit the same pixel while bright = 1.
  - At frame start (hCount = 0 and vCount = 0) the sticky bit transfers to collision and then clears.
  - collision therefore holds for one full frame.
  - Positions updated by move_tick mid-frame take effect on the next pixel. move_tick is expected during vertical blank but is not required to be.

Decomposition:
- Package vga_pkg holds:
  - RGB_W = 12.
  - Colour constants RED, GREEN, BLUE, WHITE, WHITE_HI, BACKGROUND, BLACK.
  - SPRITE_PALETTE[0:7].
  - Typedef pos_t, 10-bit unsigned.
  - Edge-mode constants WRAP_MODE and CLAMP_MODE.
- Sub-module sprite_pos holds one sprite's x/y registers, reset position and step/wrap/clamp logic. It is instantiated NUM_SPRITES times in a generate loop.
- The top level contains the selection counter, hit/priority logic, output register and collision latch.

Test Plan:
- Reset, then one frame -> sel_id = 0, collision = 0. Sprite 0 at (303, 274), sprite 1 at (463, 274), sprite 2 at (623, 274). rgb(303, 274) = palette[0] one cycle after that pixel is presented.
- WRAP = 1, sprite 0 at x = 783, right + move_tick -> x = 144. WRAP = 0, same stimulus -> x stays 783.
- up and right held together with move_tick -> only x += 2, y unchanged.
- sel_next and move_tick with left in the same cycle -> old sprite 0 moves to x = 301, sel_id = 1, sprite 1 unchanged.
- move_all = 1, down × 3 ticks -> every sprite y = 280. With WRAP = 1 starting from y = 514, one tick -> y = 35.
- Move sprite 1 onto sprite 0's position, run one frame -> collision = 1 after the next (0, 0). Overlap pixels show palette[0]. Separate the sprites and run one more frame -> collision = 0.
